// File: rtl/fir_filter.sv
// fir_filter: direct-form, fixed-coefficient, fully parallel FIR filter.
//   One sample is accepted per clock while valid is high. The sum of all
//   tap products is rounded (half-up) and saturated to DW bits, then
//   registered, giving a latency of one clock.
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous active-high reset
//   x       - signed input sample, used directly as tap 0
//   valid   - input strobe
//   d_out   - registered, rounded, saturated filter output
//   d_valid - one-cycle pulse after each accepted sample

// Per-tap multiplier. The product is full precision, so no bits are lost
// before accumulation. A zero coefficient folds away to nothing.
module fir_tap #(
  parameter int              DW   = 16,
  parameter logic [DW-1:0]   COEF = '0
) (
  input  logic [DW-1:0]   x_i,
  output logic [2*DW-1:0] prod_o
);
  logic signed [DW-1:0]   xs;
  logic signed [DW-1:0]   cs;
  logic signed [2*DW-1:0] ps;

  assign xs = x_i;
  assign cs = COEF;
  // Both operands are sign-extended to 2*DW, so the low 2*DW bits of the
  // product equal the exact signed product.
  assign ps     = (2*DW)'(xs) * (2*DW)'(cs);
  assign prod_o = ps;
endmodule

module fir_filter #(
  parameter int                  TAPS   = 16,
  parameter int                  DW     = 16,
  parameter logic [TAPS*DW-1:0]  COEFFS = {16{16'h0800}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] x,
  input  logic          valid,
  output logic [DW-1:0] d_out,
  output logic          d_valid
);
  localparam int STAGES = 1;
  localparam int AW     = 2*DW + $clog2(TAPS);

  // Rounding constant 2^(DW-2) and the saturation limits, all at AW bits.
  localparam logic signed [AW-1:0] RND  = {{(AW-DW+1){1'b0}}, 1'b1, {(DW-2){1'b0}}};
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Delay line holds x[n-1]..x[n-(TAPS-1)]; x[n] comes straight from the port.
  logic [TAPS-1:1][DW-1:0]   dly_q, dly_d;
  logic [TAPS-1:0][DW-1:0]   tap_x;
  logic [TAPS-1:0][2*DW-1:0] prod;
  logic [DW-1:0]             d_out_q, d_out_d;
  logic [STAGES:0]           vld_pipe;

  logic signed [AW-1:0]      acc;
  logic signed [AW-1:0]      rnd;
  logic signed [AW-1:0]      shf;

  assign tap_x[0] = x;

  genvar k;
  generate
    for (k = 1; k < TAPS; k++) begin : g_tapx
      assign tap_x[k] = dly_q[k];
    end
    for (k = 0; k < TAPS; k++) begin : g_tap
      fir_tap #(
        .DW   (DW),
        .COEF (COEFFS[k*DW +: DW])
      ) u_tap (
        .x_i    (tap_x[k]),
        .prod_o (prod[k])
      );
    end
  endgenerate

  // Single combinational stage: sum of sign-extended products, round, shift.
  always_comb begin
    acc = '0;
    for (int i = 0; i < TAPS; i++) begin
      acc = acc + {{(AW-2*DW){prod[i][2*DW-1]}}, prod[i]};
    end
    rnd = acc + RND;
    shf = rnd >>> (DW-1);
  end

  // Clamp instead of wrapping: a full-scale input with large coefficients
  // must pin the output at the rail, never flip sign.
  always_comb begin
    d_out_d = d_out_q;
    if (valid) begin
      if (shf > MAXV)      d_out_d = {1'b0, {(DW-1){1'b1}}};
      else if (shf < MINV) d_out_d = {1'b1, {(DW-1){1'b0}}};
      else                 d_out_d = shf[DW-1:0];
    end
  end

  // Shift only on accepted samples; gaps hold the history unchanged.
  always_comb begin
    dly_d = dly_q;
    if (valid) begin
      dly_d[1] = x;
      for (int i = 2; i < TAPS; i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end
  end

  assign vld_pipe[0] = valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly_q            <= '0;
      d_out_q          <= '0;
      vld_pipe[STAGES:1] <= '0;
    end else begin
      dly_q            <= dly_d;
      d_out_q          <= d_out_d;
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end
  end

  assign d_out   = d_out_q;
  assign d_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_fir_filter.sv
module tb_fir_filter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] x = '0;
  logic        valid = 1'b0;
  logic [15:0] d_out;
  logic        d_valid;
  logic [15:0] sx = '0;
  logic        svalid = 1'b0;
  logic [15:0] s_out;
  logic        s_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_filter u_dut (
    .clk(clk), .reset(reset), .x(x), .valid(valid),
    .d_out(d_out), .d_valid(d_valid)
  );

  fir_filter #(.COEFFS({16{16'h7FFF}})) u_sat (
    .clk(clk), .reset(reset), .x(sx), .valid(svalid),
    .d_out(s_out), .d_valid(s_valid)
  );

  // Inputs change 1ns after a rising edge; outputs are sampled at that same
  // point, well away from the next edge.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid  = 1'b0;
    svalid = 1'b0;
    reset  = 1'b1;
    repeat (2) edge1();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    valid = 1'b0;
    x     = 16'h1234;
    reset = 1'b1;
    repeat (5) begin
      edge1();
      checks++;
      if (d_out !== 16'd0 || d_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: d_out=%0d d_valid=%b, required 0/0", $signed(d_out), d_valid);
      end
    end
    reset = 1'b0;
    repeat (4) begin
      edge1();
      checks++;
      if (d_out !== 16'd0 || d_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_release: d_out=%0d d_valid=%b, required 0/0", $signed(d_out), d_valid);
      end
    end
  endtask

  task automatic test_impulse();
    int exp;
    do_reset();
    valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      x = (n == 0) ? 16'h7FFF : 16'h0000;
      edge1();
      exp = (n < 16) ? 2048 : 0;
      checks++;
      if ($signed(d_out) !== exp || d_valid !== 1'b1) begin
        errors++;
        $display("FAIL impulse[%0d]: d_out=%0d d_valid=%b, required %0d/1", n, $signed(d_out), d_valid, exp);
      end
    end
    valid = 1'b0;
  endtask

  // Hand-derived: with k samples of +1 and 16-k of -1 the output is
  // floor((k-4)/8) -> -1 for k<4, 0 for 4..11, +1 for k>=12.
  task automatic test_square();
    int exp;
    int k;
    do_reset();
    valid = 1'b1;
    x = 16'hFFFF;
    repeat (16) edge1();
    checks++;
    if ($signed(d_out) !== -1) begin
      errors++;
      $display("FAIL square_neg_steady: d_out=%0d, required -1", $signed(d_out));
    end
    for (int i = 0; i < 32; i++) begin
      x = (i < 16) ? 16'h0001 : 16'hFFFF;
      edge1();
      k = (i < 16) ? i + 1 : 31 - i;
      exp = (k < 4) ? -1 : (k < 12) ? 0 : 1;
      checks++;
      if ($signed(d_out) !== exp || d_valid !== 1'b1) begin
        errors++;
        $display("FAIL square[%0d]: d_out=%0d d_valid=%b, required %0d/1", i, $signed(d_out), d_valid, exp);
      end
    end
    valid = 1'b0;
  endtask

  // Each accepted 0x1000 sample adds 256; gap cycles carry junk on x.
  task automatic test_valid_gaps();
    int acc_n;
    int exp;
    do_reset();
    acc_n = 0;
    for (int c = 0; c < 40; c++) begin
      valid = (c % 2 == 0);
      x     = valid ? 16'h1000 : 16'hDEAD;
      if (valid) acc_n++;
      edge1();
      exp = 256 * ((acc_n > 16) ? 16 : acc_n);
      checks++;
      if ($signed(d_out) !== exp || d_valid !== valid) begin
        errors++;
        $display("FAIL gaps[%0d]: d_out=%0d d_valid=%b, required %0d/%b", c, $signed(d_out), d_valid, exp, valid);
      end
    end
    valid = 1'b0;
  endtask

  // Coefficients 0x7FFF: one full-scale sample gives 32766 / -32767, two or
  // more push past the rails.
  task automatic test_saturation();
    int exp;
    do_reset();
    svalid = 1'b1;
    sx = 16'h7FFF;
    for (int m = 1; m <= 16; m++) begin
      edge1();
      exp = (m == 1) ? 32766 : 32767;
      checks++;
      if ($signed(s_out) !== exp || s_valid !== 1'b1) begin
        errors++;
        $display("FAIL sat_pos[%0d]: d_out=%0d d_valid=%b, required %0d/1", m, $signed(s_out), s_valid, exp);
      end
    end
    do_reset();
    svalid = 1'b1;
    sx = 16'h8000;
    for (int m = 1; m <= 16; m++) begin
      edge1();
      exp = (m == 1) ? -32767 : -32768;
      checks++;
      if ($signed(s_out) !== exp || s_valid !== 1'b1) begin
        errors++;
        $display("FAIL sat_neg[%0d]: d_out=%0d d_valid=%b, required %0d/1", m, $signed(s_out), s_valid, exp);
      end
    end
    svalid = 1'b0;
  endtask

  // 0x7FFF through 1/16 taps: m samples give 2048m for m<=8, 2048m-1 beyond.
  task automatic test_midstream_reset();
    int exp;
    do_reset();
    valid = 1'b1;
    x = 16'h7FFF;
    repeat (10) edge1();
    checks++;
    if ($signed(d_out) !== 20479) begin
      errors++;
      $display("FAIL pre_reset: d_out=%0d, required 20479", $signed(d_out));
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (d_out !== 16'd0 || d_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: d_out=%0d d_valid=%b, required 0/0", $signed(d_out), d_valid);
    end
    edge1();
    reset = 1'b0;
    for (int m = 1; m <= 12; m++) begin
      edge1();
      exp = (m <= 8) ? 2048 * m : 2048 * m - 1;
      checks++;
      if ($signed(d_out) !== exp || d_valid !== 1'b1) begin
        errors++;
        $display("FAIL ramp[%0d]: d_out=%0d d_valid=%b, required %0d/1", m, $signed(d_out), d_valid, exp);
      end
    end
    valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_square();
    test_valid_gaps();
    test_saturation();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
